// File: rtl/phy_rx.sv
// phy_rx: two-lane byte receiver that packs each lane into 32-bit words and un-stripes them in transmit order
//   clk_4f/reset        byte clock, asynchronous active-low reset
//   data_in_x/valid_in_x lane x byte and qualifier (x = 0, 1)
//   data_out/valid_out  reassembled word stream, registered
//   err_ovf/err_frag    sticky lane FIFO overflow / aborted partial word
module phy_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in_0,
    input  logic        valid_in_0,
    input  logic [7:0]  data_in_1,
    input  logic        valid_in_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        err_ovf,
    output logic        err_frag
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]  cnt [2];
    logic [23:0] sr  [2];
    logic [31:0] mem [2][FIFO_DEPTH];
    logic [AW:0] wp  [2];
    logic [AW:0] rp  [2];
    logic [7:0]  din [2];
    logic [1:0]  vin, push, pop, wr, full, empty, frag;
    logic        sel;

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign vin    = {valid_in_1, valid_in_0};

    // A push into a full FIFO still lands when the same edge pops a slot
    always_comb begin
        push  = '0;
        pop   = '0;
        wr    = '0;
        full  = '0;
        empty = '0;
        frag  = '0;
        for (int i = 0; i < 2; i++) begin
            empty[i] = wp[i] == rp[i];
            full[i]  = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
            push[i]  = vin[i] && cnt[i] == 2'd3;
            pop[i]   = (sel == 1'(i)) && !empty[i];
            wr[i]    = push[i] && (!full[i] || pop[i]);
            frag[i]  = !vin[i] && cnt[i] != 2'd0;
        end
    end

    always_ff @(posedge clk_4f) begin
        for (int i = 0; i < 2; i++)
            if (wr[i]) mem[i][wp[i][AW-1:0]] <= {sr[i], din[i]};
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
                sr[i]  <= '0;
                wp[i]  <= '0;
                rp[i]  <= '0;
            end
            sel       <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err_ovf   <= 1'b0;
            err_frag  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= vin[i] ? cnt[i] + 2'd1 : 2'd0;
                if (vin[i]) sr[i] <= {sr[i][15:0], din[i]};
                if (wr[i]) wp[i] <= wp[i] + (AW+1)'(1);
                if (pop[i]) rp[i] <= rp[i] + (AW+1)'(1);
            end
            // Only the selected lane may pop, so a stalled lane blocks the other
            if (|pop) data_out <= mem[sel][rp[sel][AW-1:0]];
            valid_out <= |pop;
            sel       <= sel ^ (|pop);
            err_ovf   <= err_ovf | (|(push & full & ~pop));
            err_frag  <= err_frag | (|frag);
        end
    end
endmodule

// File: doc/phy_rx.md
# phy_rx

Receive side of the two-lane PCIe PHY datapath. Accepts the two 8-bit lanes produced by the transmit path, reassembles each lane's bytes into 32-bit words, and un-stripes the two lanes back into the original single 32-bit word stream in transmit order. Runs entirely in the byte-clock domain: words leave as a registered `valid_out`-qualified stream, at most one per cycle, with no derived clocks.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: per-lane word buffer depth. Must be a power of 2 and at least 2.

Ports:
- `clk_4f`, input, 1: byte clock. All state is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `data_in_0`, input, 8: lane 0 byte.
- `valid_in_0`, input, 1: lane 0 byte qualifier.
- `data_in_1`, input, 8: lane 1 byte.
- `valid_in_1`, input, 1: lane 1 byte qualifier.
- `data_out`, output, 32: reassembled word, registered.
- `valid_out`, output, 1: `data_out` qualifier, registered.
- `err_ovf`, output, 1: sticky flag; a lane FIFO overflowed.
- `err_frag`, output, 1: sticky flag; a partial word was aborted.

## Operation
Stream format (fixed by the transmit path):
- Words alternate lanes: word 0 on lane 0, word 1 on lane 1, word 2 on lane 0, and so on.
- Each word occupies 4 consecutive valid bytes on its lane, MSB first: [31:24], [23:16], [15:8], [7:0].

Per-lane packer (two identical instances):
- 2-bit byte counter `cnt` plus a 24-bit shift register.
- When `valid_in_x`=1: the byte is stored and `cnt` increments.
- When `cnt`=3 and `valid_in_x`=1: the assembled word {stored 3 bytes, current byte} is pushed into the lane FIFO on that edge, and `cnt` wraps to 0.
- When `valid_in_x`=0 and `cnt`≠0: the partial word is discarded, `cnt` goes to 0, and `err_frag` is set.
- `valid_in_x`=0 with `cnt`=0 is idle and has no effect.

Lane FIFO (one per lane):
- `FIFO_DEPTH` entries, with read/write pointers one bit wider than the address for full/empty detection.
- Push while full and no pop on the same edge: the word is dropped, the FIFO is unchanged, and `err_ovf` is set.
- Push and pop on the same edge while full: both occur. This is not an overflow.

Un-striper:
- A 1-bit pointer `sel` selects the expected lane and resets to 0.
- Each cycle, if FIFO[`sel`] is non-empty: pop it, register the word into `data_out`, set `valid_out`=1, and toggle `sel`.
- If FIFO[`sel`] is empty: `valid_out`=0, `data_out` holds its last value, and `sel` is unchanged. The other lane is never skipped ahead, so word order is always preserved.

Error flags:
- `err_ovf` and `err_frag` are sticky; only `reset` clears them.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `err_ovf`=0, `err_frag`=0, `sel`=0, both `cnt`=0, both FIFOs empty.
- Asynchronous assertion takes effect immediately, including mid-word. Any partial words and buffered words are lost.
- Latency: if the last byte of a word is sampled at edge k and its lane is selected and otherwise empty, `valid_out`=1 with that word after edge k+1.
- Simultaneous completion on both lanes at edge k: lane 0's word is output after edge k+1 and lane 1's word after edge k+2, assuming `sel`=0.
- Throughput: the sustained input rate is 2 words per 4 cycles and the output can deliver 1 word per cycle, so there is no overflow in steady state.
- Overflow occurs only when one lane runs ahead of the other by more than `FIFO_DEPTH` words.
- `err_frag` and `err_ovf` are visible after the edge on which the offending condition is sampled.

## Test plan
- Reset: drive `reset`=0 asynchronously mid-stream -> all outputs 0 immediately. After release, the first word comes from lane 0.
- Aligned pair: lane 0 bytes AA,BB,CC,DD and lane 1 bytes 11,22,33,44 on cycles 0-3 -> 0xAABBCCDD after edge 4, then 0x11223344 after edge 5. `valid_out`=0 on cycle 6.
- Ordering stall: lane 1 sends 0x11223344 first, then lane 0 sends 0xAABBCCDD 8 cycles later -> no output until the lane 0 word completes. Then 0xAABBCCDD and 0x11223344 come out back-to-back.
- Fragment: lane 0 sends AA,BB, then drops valid for 1 cycle, then sends 01,02,03,04 -> `err_frag`=1 and stays 1. The output is 0x01020304 only.
- Overflow (`FIFO_DEPTH`=4): lane 0 sends 6 words while lane 1 stays idle -> words 0 and 1 are not blocked by lane 1 only if lane 1 delivers; with lane 1 idle, only the first lane 0 word is output. FIFO 0 fills and `err_ovf`=1 on the push that finds it full with no pop. The dropped word never appears on `data_out`.
- Sustained: 64 random words striped continuously -> output equals the input sequence exactly, and `err_ovf`=`err_frag`=0.
